// File: rtl/cordic_dual_if.sv
// Sample-stream bundle for cordic_dual: input sample, pipeline clock enable and result.
// in_valid/out_valid are plain qualifiers with no backpressure; a sample moves one stage per cycle with ce=1.
interface cordic_dual_if #(
  parameter int width = 16
);
  logic                    ce;
  logic                    in_valid;
  logic                    mode_in;
  logic signed [width-1:0] x0;
  logic signed [width-1:0] y0;
  logic signed [width-1:0] z0;
  logic                    out_valid;
  logic                    mode_out;
  logic signed [width-1:0] x;
  logic signed [width-1:0] y;
  logic signed [width-1:0] z;
  logic                    sat;

  modport slave (
    input  ce, in_valid, mode_in, x0, y0, z0,
    output out_valid, mode_out, x, y, z, sat
  );

  modport master (
    output ce, in_valid, mode_in, x0, y0, z0,
    input  out_valid, mode_out, x, y, z, sat
  );
endinterface

// File: rtl/cordic_dual.sv
// Pipelined dual-mode CORDIC (rotation/vectoring per sample) with ce stall and output saturation.
// Optional gain-compensation stage enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_dual #(
  parameter int width      = 16,
  parameter int iterations = width + 1,
  parameter int guard_bits = $clog2(iterations)
) (
  input logic          clk,
  input logic          reset,
  cordic_dual_if.slave bus
);

  localparam int XW = width + guard_bits + 2;
  localparam int ZW = width + guard_bits;
  localparam int NS = iterations + 1;

  typedef logic [iterations-1:0][ZW-1:0] atan_tab_t;

  // atan(2^-i) in angle units where pi = 2^(ZW-1)
  function automatic atan_tab_t gen_atan();
    atan_tab_t t;
    real       scale;
    scale = (2.0 ** (ZW - 1)) / 3.14159265358979323846;
    for (int i = 0; i < iterations; i++) begin
      t[i] = ZW'($rtoi(scale * $atan(2.0 ** (-i)) + 0.5));
    end
    return t;
  endfunction

  localparam atan_tab_t ATAN_TAB = gen_atan();

  logic signed [XW-1:0] x_q [NS];
  logic signed [XW-1:0] y_q [NS];
  logic signed [ZW-1:0] z_q [NS];
  logic signed [XW-1:0] x_d [NS];
  logic signed [XW-1:0] y_d [NS];
  logic signed [ZW-1:0] z_d [NS];
  logic                 v_q [NS];
  logic                 m_q [NS];

  logic signed [XW-1:0] x_ext;
  logic signed [XW-1:0] y_ext;
  logic signed [ZW-1:0] z_ext;
  logic                 flip;

  assign x_ext = {{2{bus.x0[width-1]}}, bus.x0, {guard_bits{1'b0}}};
  assign y_ext = {{2{bus.y0[width-1]}}, bus.y0, {guard_bits{1'b0}}};
  assign z_ext = {bus.z0, {guard_bits{1'b0}}};

  // Adding or subtracting pi is the same MSB flip modulo 2*pi.
  assign flip   = bus.mode_in ? bus.x0[width-1] : (bus.z0[width-1] ^ bus.z0[width-2]);
  assign x_d[0] = flip ? -x_ext : x_ext;
  assign y_d[0] = flip ? -y_ext : y_ext;
  assign z_d[0] = flip ? {~z_ext[ZW-1], z_ext[ZW-2:0]} : z_ext;

  for (genvar i = 0; i < iterations; i++) begin : g_stage
    localparam logic signed [XW-1:0] RND    = XW'((2 ** i) >> 1);
    localparam logic signed [ZW-1:0] ATAN_I = ATAN_TAB[i];
    logic signed [XW-1:0] xs;
    logic signed [XW-1:0] ys;
    logic                 dpos;

    assign xs   = (x_q[i] + RND) >>> i;
    assign ys   = (y_q[i] + RND) >>> i;
    assign dpos = m_q[i] ? y_q[i][XW-1] : ~z_q[i][ZW-1];

    assign x_d[i+1] = dpos ? (x_q[i] - ys) : (x_q[i] + ys);
    assign y_d[i+1] = dpos ? (y_q[i] + xs) : (y_q[i] - xs);
    assign z_d[i+1] = dpos ? (z_q[i] - ATAN_I) : (z_q[i] + ATAN_I);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NS; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
        z_q[k] <= '0;
        v_q[k] <= 1'b0;
        m_q[k] <= 1'b0;
      end
    end else if (bus.ce) begin
      v_q[0] <= bus.in_valid;
      m_q[0] <= bus.mode_in;
      for (int k = 0; k < NS; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
        z_q[k] <= z_d[k];
      end
      for (int k = 1; k < NS; k++) begin
        v_q[k] <= v_q[k-1];
        m_q[k] <= m_q[k-1];
      end
    end
  end

  logic signed [XW-1:0] x_last;
  logic signed [XW-1:0] y_last;
  logic signed [ZW-1:0] z_last;
  logic                 v_last;
  logic                 m_last;

`ifdef CORDIC_GAIN_COMP_EN
  function automatic real cordic_gain();
    real k;
    k = 1.0;
    for (int i = 0; i < iterations; i++) begin
      k = k * $sqrt(1.0 + 2.0 ** (-2 * i));
    end
    return k;
  endfunction

  // Q2.(width+1) reciprocal of the accumulated CORDIC gain
  localparam int PW = XW + width + 3;
  localparam int GAIN = $rtoi((2.0 ** (width + 1)) / cordic_gain() + 0.5);
  localparam logic signed [PW-1:0] GAIN_S = PW'(GAIN);
  localparam logic signed [PW-1:0] GRND   = PW'(2 ** width);

  logic signed [XW-1:0] xg_q;
  logic signed [XW-1:0] yg_q;
  logic signed [ZW-1:0] zg_q;
  logic                 vg_q;
  logic                 mg_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xg_q <= '0;
      yg_q <= '0;
      zg_q <= '0;
      vg_q <= 1'b0;
      mg_q <= 1'b0;
    end else if (bus.ce) begin
      xg_q <= XW'((x_q[NS-1] * GAIN_S + GRND) >>> (width + 1));
      yg_q <= XW'((y_q[NS-1] * GAIN_S + GRND) >>> (width + 1));
      zg_q <= z_q[NS-1];
      vg_q <= v_q[NS-1];
      mg_q <= m_q[NS-1];
    end
  end

  assign x_last = xg_q;
  assign y_last = yg_q;
  assign z_last = zg_q;
  assign v_last = vg_q;
  assign m_last = mg_q;
`else
  assign x_last = x_q[NS-1];
  assign y_last = y_q[NS-1];
  assign z_last = z_q[NS-1];
  assign v_last = v_q[NS-1];
  assign m_last = m_q[NS-1];
`endif

  localparam logic signed [XW-1:0] ORND = XW'((2 ** guard_bits) >> 1);
  localparam logic signed [ZW-1:0] ZRND = ZW'((2 ** guard_bits) >> 1);
  localparam logic signed [XW-1:0] SMAX = XW'(2 ** (width - 1) - 1);
  localparam logic signed [XW-1:0] SMIN = -SMAX;

  logic signed [XW-1:0]    xr;
  logic signed [XW-1:0]    yr;
  logic signed [width-1:0] x_sat_d;
  logic signed [width-1:0] y_sat_d;
  logic                    x_clip;
  logic                    y_clip;

  assign xr = (x_last + ORND) >>> guard_bits;
  assign yr = (y_last + ORND) >>> guard_bits;

  always_comb begin
    x_sat_d = xr[width-1:0];
    y_sat_d = yr[width-1:0];
    x_clip  = 1'b0;
    y_clip  = 1'b0;
    if (xr > SMAX) begin
      x_sat_d = width'(SMAX);
      x_clip  = 1'b1;
    end else if (xr < SMIN) begin
      x_sat_d = width'(SMIN);
      x_clip  = 1'b1;
    end
    if (yr > SMAX) begin
      y_sat_d = width'(SMAX);
      y_clip  = 1'b1;
    end else if (yr < SMIN) begin
      y_sat_d = width'(SMIN);
      y_clip  = 1'b1;
    end
  end

  logic signed [width-1:0] x_out_q;
  logic signed [width-1:0] y_out_q;
  logic signed [width-1:0] z_out_q;
  logic                    sat_q;
  logic                    out_valid_q;
  logic                    mode_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_out_q     <= '0;
      y_out_q     <= '0;
      z_out_q     <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      mode_out_q  <= 1'b0;
    end else if (bus.ce) begin
      x_out_q     <= x_sat_d;
      y_out_q     <= y_sat_d;
      z_out_q     <= width'((z_last + ZRND) >>> guard_bits);
      sat_q       <= x_clip | y_clip;
      out_valid_q <= v_last;
      mode_out_q  <= m_last;
    end
  end

  assign bus.x         = x_out_q;
  assign bus.y         = y_out_q;
  assign bus.z         = z_out_q;
  assign bus.sat       = sat_q;
  assign bus.out_valid = out_valid_q;
  assign bus.mode_out  = mode_out_q;

endmodule

// File: tb/tb_cordic_dual.sv
// Directed bench for cordic_dual: latency, both modes, interleave, saturation, stall, reset.
module tb_cordic_dual;

`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT   = 20;
  localparam int A45   = 11585;
  localparam int VMAG  = 14142;
  localparam int VNEG  = 10000;
  localparam int MAG   = 16384;
  localparam int XEDGE = 2;
`else
  localparam int LAT   = 19;
  localparam int A45   = 19079;
  localparam int VMAG  = 23289;
  localparam int VNEG  = 16468;
  localparam int MAG   = 26981;
  localparam int XEDGE = 3;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  cordic_dual_if #(.width(16)) bus ();

  cordic_dual #(.width(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input int xi, input int yi, input int zi);
    bus.in_valid = v;
    bus.mode_in  = m;
    bus.x0       = 16'(xi);
    bus.y0       = 16'(yi);
    bus.z0       = 16'(zi);
  endtask

  task automatic chk(input string tag, input int act, input int exp, input int tol);
    int d;
    bit ok;
    d  = act - exp;
    if (d < 0) d = -d;
    ok = (d <= tol);
    n_checks++;
    assert (ok === 1'b1) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d tol %0d", tag, act, exp, tol);
    end
  endtask

  // z wraps modulo 2*pi, so compare on the 16-bit circle
  task automatic chk_ang(input string tag, input int act, input int exp, input int tol);
    logic signed [15:0] d16;
    int d;
    bit ok;
    d16 = 16'(act - exp);
    d   = int'(d16);
    if (d < 0) d = -d;
    ok = (d <= tol);
    n_checks++;
    assert (ok === 1'b1) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d tol %0d", tag, act, exp, tol);
    end
  endtask

  task automatic expect_out(input string tag, input int m, input int ex, input int tx,
                            input int ey, input int ty, input int ez, input int tz);
    chk({tag, ".valid"}, int'(bus.out_valid), 1, 0);
    chk({tag, ".mode"}, int'(bus.mode_out), m, 0);
    chk({tag, ".x"}, int'(bus.x), ex, tx);
    chk({tag, ".y"}, int'(bus.y), ey, ty);
    chk_ang({tag, ".z"}, int'(bus.z), ez, tz);
  endtask

  task automatic expect_zero(input string tag);
    chk({tag, ".valid"}, int'(bus.out_valid), 0, 0);
    chk({tag, ".mode"}, int'(bus.mode_out), 0, 0);
    chk({tag, ".x"}, int'(bus.x), 0, 0);
    chk({tag, ".y"}, int'(bus.y), 0, 0);
    chk({tag, ".z"}, int'(bus.z), 0, 0);
    chk({tag, ".sat"}, int'(bus.sat), 0, 0);
  endtask

  task automatic run_one(input logic m, input int xi, input int yi, input int zi);
    drive(1'b1, m, xi, yi, zi);
    step();
    drive(1'b0, 1'b0, 0, 0, 0);
    repeat (LAT - 1) step();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset    = 1'b1;
    bus.ce   = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 0);
    #12;
    expect_zero("reset");
    step();
    reset = 1'b0;

    // rotation by pi/4 with explicit latency check
    drive(1'b1, 1'b0, 16384, 0, 8192);
    step();
    drive(1'b0, 1'b0, 0, 0, 0);
    repeat (LAT - 2) step();
    chk("rot45.early", int'(bus.out_valid), 0, 0);
    step();
    expect_out("rot45", 0, A45, 3, A45, 3, 0, 2);
    chk("rot45.sat", int'(bus.sat), 0, 0);

    run_one(1'b1, 10000, 10000, 0);
    expect_out("vec45", 1, VMAG, 3, 0, 3, 8192, 2);

    run_one(1'b1, -10000, 0, 0);
    expect_out("vecneg", 1, VNEG, 3, 0, 3, -32768, 2);

    run_one(1'b0, 32767, 32767, 0);
`ifdef CORDIC_GAIN_COMP_EN
    expect_out("satq", 0, 32767, 2, 32767, 2, 0, 2);
`else
    expect_out("satq", 0, 32767, 0, 32767, 0, 0, 2);
    chk("satq.sat", int'(bus.sat), 1, 0);
`endif

    run_one(1'b0, 32767, 32767, 8192);
    expect_out("sat45", 0, 0, 3, 32767, 0, 0, 2);
    chk("sat45.sat", int'(bus.sat), 1, 0);

    // quadrant-boundary sweep, issued back to back
    drive(1'b1, 1'b0, 16384, 0, 16383);  step();
    drive(1'b1, 1'b0, 16384, 0, 16384);  step();
    drive(1'b1, 1'b0, 16384, 0, -16384); step();
    drive(1'b1, 1'b0, 16384, 0, -32768); step();
    drive(1'b0, 1'b0, 0, 0, 0);
    repeat (LAT - 4) step();
    expect_out("sw16383", 0, XEDGE, 3, MAG, 3, 0, 2);
    chk("sw16383.sat", int'(bus.sat), 0, 0);
    step();
    expect_out("sw16384", 0, 0, 3, MAG, 3, 0, 2);
    step();
    expect_out("swm16384", 0, 0, 3, -MAG, 3, 0, 2);
    step();
    expect_out("swm32768", 0, -MAG, 3, 0, 3, 0, 2);
    chk("swm32768.sat", int'(bus.sat), 0, 0);

    // interleave: valid 1,0,1,1 with mode 0,1,0,1
    drive(1'b1, 1'b0, 16384, 0, 8192);   step();
    drive(1'b0, 1'b1, 1234, -999, 77);   step();
    drive(1'b1, 1'b0, 16384, 0, 16384);  step();
    drive(1'b1, 1'b1, 10000, 10000, 0);  step();
    drive(1'b0, 1'b0, 0, 0, 0);
    repeat (LAT - 4) step();
    expect_out("il0", 0, A45, 3, A45, 3, 0, 2);
    step();
    chk("il1.valid", int'(bus.out_valid), 0, 0);
    chk("il1.mode", int'(bus.mode_out), 1, 0);
    step();
    expect_out("il2", 0, 0, 3, MAG, 3, 0, 2);
    step();
    expect_out("il3", 1, VMAG, 3, 0, 3, 8192, 2);

    // stall with a sample at the output and two more in flight
    drive(1'b1, 1'b0, 16384, 0, 8192);   step();
    drive(1'b1, 1'b1, 10000, 10000, 0);  step();
    drive(1'b1, 1'b0, 16384, 0, 16384);  step();
    drive(1'b0, 1'b0, 0, 0, 0);
    repeat (LAT - 3) step();
    expect_out("st.a", 0, A45, 3, A45, 3, 0, 2);
    bus.ce = 1'b0;
    drive(1'b1, 1'b1, -5000, 3000, 100);
    for (int k = 0; k < 5; k++) begin
      step();
      expect_out("st.hold", 0, A45, 3, A45, 3, 0, 2);
    end
    drive(1'b0, 1'b0, 0, 0, 0);
    bus.ce = 1'b1;
    step();
    expect_out("st.b", 1, VMAG, 3, 0, 3, 8192, 2);
    step();
    expect_out("st.c", 0, 0, 3, MAG, 3, 0, 2);
    for (int k = 0; k < LAT; k++) begin
      step();
      chk("st.drain", int'(bus.out_valid), 0, 0);
    end

    // reset with a full pipeline
    drive(1'b1, 1'b0, 16384, 0, 8192);
    repeat (LAT + 9) step();
    expect_out("rs.pre", 0, A45, 3, A45, 3, 0, 2);
    #2;
    reset = 1'b1;
    #1;
    expect_zero("rs.async");
    drive(1'b0, 1'b0, 0, 0, 0);
    step();
    reset = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      step();
      chk("rs.quiet", int'(bus.out_valid), 0, 0);
    end
    drive(1'b1, 1'b1, 10000, 10000, 0);
    step();
    drive(1'b0, 1'b0, 0, 0, 0);
    repeat (LAT - 2) step();
    chk("rs.early", int'(bus.out_valid), 0, 0);
    step();
    expect_out("rs.new", 1, VMAG, 3, 0, 3, 8192, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
